// File: rtl/ac_motor_pkg.sv
// Shared types and constants for the AC motor inverter gate path.
// Holds the gate guard state encoding and the leg count.
package ac_motor_pkg;

    localparam int AC_MOTOR_LEGS = 3;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_RUN        = 2'd1,
        ST_FAULT      = 2'd2,
        ST_WAIT_CLEAR = 2'd3
    } gate_guard_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ac_motor_min_pulse_filter.sv
// Min-on filter for one gate: output rises after MIN_PULSE consecutive high samples.
// Latency: MIN_PULSE edges to turn on, 1 edge to turn off; no backpressure.
module ac_motor_min_pulse_filter #(
    parameter int MIN_PULSE = 16,
    parameter int CNT_W     = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    input  logic in,
    output logic out
);

    localparam logic [CNT_W-1:0] MIN_P = CNT_W'(MIN_PULSE);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_q, out_d;

    always_comb begin
        cnt_d = '0;
        out_d = 1'b0;
        if (!flush && in) begin
            // Saturate so a long pulse keeps the gate on without wrapping.
            cnt_d = (cnt_q == MIN_P) ? cnt_q : cnt_q + CNT_W'(1);
            out_d = (cnt_d == MIN_P);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            out_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: rtl/ac_motor_gate_guard.sv
// Final gate protection: min-on filtering, shoot-through fault latch with timed hold and clear.
// Latency: MIN_PULSE edges on, 1 edge off, gates drop on the shoot-through edge; no backpressure.
module ac_motor_gate_guard
    import ac_motor_pkg::*;
#(
    parameter int MIN_PULSE  = 16,
    parameter int FAULT_HOLD = 1024,
    parameter int CNT_W      = 11
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [AC_MOTOR_LEGS-1:0] s_high_in,
    input  logic [AC_MOTOR_LEGS-1:0] s_low_in,
    output logic [AC_MOTOR_LEGS-1:0] g_high,
    output logic [AC_MOTOR_LEGS-1:0] g_low,
    output logic                     fault,
    output logic [AC_MOTOR_LEGS-1:0] fault_code,
    output logic [7:0]               fault_count
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(FAULT_HOLD - 1);

    gate_guard_state_t        state_q, state_d;
    logic [CNT_W-1:0]         hold_q, hold_d;
    logic                     fault_q, fault_d;
    logic [AC_MOTOR_LEGS-1:0] code_q, code_d;
    logic [7:0]               count_q, count_d;
    logic [AC_MOTOR_LEGS-1:0] shoot;
    logic                     inputs_idle;
    logic                     flush;

    assign shoot       = s_high_in & s_low_in;
    assign inputs_idle = ~|{s_high_in, s_low_in};

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        code_d  = code_q;
        count_d = count_q;
        flush   = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                // Shoot-through wins over a same-edge enable drop.
                if (|shoot) begin
                    state_d = ST_FAULT;
                    code_d  = code_q | shoot;
                    count_d = sat_inc8(count_q);
                    hold_d  = '0;
                end else if (!enable) begin
                    state_d = ST_IDLE;
                end else begin
                    flush = 1'b0;
                end
            end
            ST_FAULT: begin
                code_d = code_q | shoot;
                if (hold_q == HOLD_LAST) state_d = ST_WAIT_CLEAR;
                else                     hold_d  = hold_q + CNT_W'(1);
            end
            ST_WAIT_CLEAR: begin
                if (clear && inputs_idle) begin
                    code_d  = '0;
                    state_d = enable ? ST_RUN : ST_IDLE;
                end else begin
                    code_d = code_q | shoot;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        fault_d = (state_d == ST_FAULT) || (state_d == ST_WAIT_CLEAR);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            fault_q <= 1'b0;
            code_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            fault_q <= fault_d;
            code_q  <= code_d;
            count_q <= count_d;
        end
    end

    for (genvar i = 0; i < AC_MOTOR_LEGS; i++) begin : g_leg
        ac_motor_min_pulse_filter #(
            .MIN_PULSE(MIN_PULSE),
            .CNT_W    (CNT_W)
        ) u_hi (
            .clk  (clk),
            .rst_n(rst_n),
            .flush(flush),
            .in   (s_high_in[i]),
            .out  (g_high[i])
        );
        ac_motor_min_pulse_filter #(
            .MIN_PULSE(MIN_PULSE),
            .CNT_W    (CNT_W)
        ) u_lo (
            .clk  (clk),
            .rst_n(rst_n),
            .flush(flush),
            .in   (s_low_in[i]),
            .out  (g_low[i])
        );
    end

    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign fault_count = count_q;

endmodule
